// File: rtl/obm_dma_controller_pkg.sv
// Shared definitions for the OBM DMA controller: VRAM geometry and FSM encoding.
package obm_dma_controller_pkg;

    localparam int          VRAM_ADDR_WIDTH = 12;
    localparam logic [11:0] OBM_BASE_ADDR   = 12'h800;
    localparam int          OBM_BYTES       = 256;

    typedef logic [1:0] dma_state_t;

    localparam dma_state_t IDLE  = 2'd0;
    localparam dma_state_t FETCH = 2'd1;
    localparam dma_state_t WRITE = 2'd2;
    localparam dma_state_t DONE  = 2'd3;

endpackage

// File: rtl/obm_dma_controller_if.sv
// CPU bus, system-memory read port and foreground VRAM write port seen by the DMA block.
interface obm_dma_controller_if;
    import obm_dma_controller_pkg::*;

    logic                       writable;
    logic                       cpu_we;
    logic [VRAM_ADDR_WIDTH-1:0] cpu_addr;
    logic [7:0]                 cpu_data;
    logic                       dma_start;
    logic [7:0]                 dma_page;
    logic                       mem_req;
    logic [15:0]                mem_addr;
    logic                       mem_ack;
    logic [7:0]                 mem_rdata;
    logic                       vram_we;
    logic [VRAM_ADDR_WIDTH-1:0] vram_addr;
    logic [7:0]                 vram_data;
    logic                       busy;
    logic                       done;

    // Controller side.
    modport master (
        input  writable, cpu_we, cpu_addr, cpu_data, dma_start, dma_page,
        input  mem_ack, mem_rdata,
        output mem_req, mem_addr, vram_we, vram_addr, vram_data, busy, done
    );

    // Environment side (CPU, memory, foreground).
    modport slave (
        output writable, cpu_we, cpu_addr, cpu_data, dma_start, dma_page,
        output mem_ack, mem_rdata,
        input  mem_req, mem_addr, vram_we, vram_addr, vram_data, busy, done
    );

endinterface

// File: rtl/obm_dma_controller.sv
// Copies one 256-byte system-memory page into OBM, sharing the VRAM write port
// with the CPU. The CPU always wins the port; the DMA simply waits a cycle.
module obm_dma_controller
    import obm_dma_controller_pkg::*;
#(
    parameter int                         NUM_BYTES = OBM_BYTES,
    parameter logic [VRAM_ADDR_WIDTH-1:0] OBM_BASE  = OBM_BASE_ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    obm_dma_controller_if.master bus
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

    dma_state_t state_q, state_d;
    logic [7:0] idx_q,   idx_d;
    logic [7:0] page_q,  page_d;
    logic [7:0] buf_q,   buf_d;
    logic       dma_we;

    // DMA owns the port only when the window is open and the CPU is not writing.
    assign dma_we = (state_q == WRITE) && bus.writable && !bus.cpu_we;

    // Transfer sequencing: one fetch then one write per byte.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (bus.dma_start) begin
                    page_d  = bus.dma_page;
                    idx_d   = 8'd0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    buf_d   = bus.mem_rdata;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (dma_we) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any transfer without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
            page_q  <= 8'd0;
            buf_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            buf_q   <= buf_d;
        end
    end

    // Request is a pure function of state, so it stays stable until acked.
    assign bus.mem_req  = (state_q == FETCH);
    assign bus.mem_addr = {page_q, idx_q};
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);

    // VRAM write port mux: CPU first, DMA otherwise.
    always_comb begin
        bus.vram_we   = 1'b0;
        bus.vram_addr = OBM_BASE + VRAM_ADDR_WIDTH'(idx_q);
        bus.vram_data = buf_q;
        if (bus.cpu_we) begin
            bus.vram_we   = 1'b1;
            bus.vram_addr = bus.cpu_addr;
            bus.vram_data = bus.cpu_data;
        end else if (dma_we) begin
            bus.vram_we   = 1'b1;
        end
    end

endmodule
